// File: rtl/mdu_unit_if.sv
// Issue/readback bundle between the E stage and the multiply/divide unit.
// The master drives the operation request; the slave returns Start, Busy and the HI/LO views.
interface mdu_unit_if;
  logic        En;
  logic [2:0]  MduOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        RdSel;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] RD;

  modport master (
    output En, MduOp, A, B, RdSel,
    input  Start, Busy, HI, LO, RD
  );

  modport slave (
    input  En, MduOp, A, B, RdSel,
    output Start, Busy, HI, LO, RD
  );
endinterface

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit with architectural HI/LO and fixed-latency Busy.
// Define MDU_DIVZERO_HOLD_EN to leave HI/LO untouched when dividing by zero.
module mdu_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_unit_if.slave bus
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [31:0]       phi_q, phi_d;
  logic [31:0]       plo_q, plo_d;
  logic              pwr_q, pwr_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  logic              is_mul, is_div, start;
  logic signed [63:0] prod_s;
  logic [63:0]       prod_u;
  logic              a_neg, b_neg;
  logic [31:0]       a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;
  logic [31:0]       res_hi, res_lo;
  logic              res_wr;

  assign is_mul = (bus.MduOp == OpMult) || (bus.MduOp == OpMultu);
  assign is_div = (bus.MduOp == OpDiv) || (bus.MduOp == OpDivu);
  assign start  = bus.En && (is_mul || is_div) && !busy_q;

  // Division works on magnitudes so the -2^31 / -1 case falls out without overflow.
  always_comb begin
    prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    a_neg  = (bus.MduOp == OpDiv) && bus.A[31];
    b_neg  = (bus.MduOp == OpDiv) && bus.B[31];
    a_mag  = a_neg ? (32'd0 - bus.A) : bus.A;
    b_mag  = b_neg ? (32'd0 - bus.B) : bus.B;
    b_div  = (bus.B == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_div;
    r_mag  = a_mag % b_div;
    quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem    = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b1;
    case (bus.MduOp)
      OpMult: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OpMultu: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OpDiv, OpDivu: begin
        if (bus.B == 32'd0) begin
`ifdef MDU_DIVZERO_HOLD_EN
          res_wr = 1'b0;
`else
          res_hi = bus.A;
          res_lo = 32'hFFFF_FFFF;
`endif
        end else begin
          res_hi = rem;
          res_lo = quo;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwr_d   = pwr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          phi_d   = res_hi;
          plo_d   = res_lo;
          pwr_d   = res_wr;
          cnt_d   = is_mul ? CntW'(MUL_CYCLES) : CntW'(DIV_CYCLES);
          busy_d  = 1'b1;
          state_d = StRun;
        end else if (bus.En && (bus.MduOp == OpMthi)) begin
          hi_d = bus.A;
        end else if (bus.En && (bus.MduOp == OpMtlo)) begin
          lo_d = bus.A;
        end
      end
      StRun: begin
        // Requests arriving here, including on the completion edge, are dropped.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          if (pwr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      pwr_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwr_q   <= pwr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.Start = start;
  assign bus.Busy  = busy_q;
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;
  assign bus.RD    = bus.RdSel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed test-plan steps plus randomized operations
// checked against a 64-bit arithmetic reference model of HI/LO.
module tb_mdu_unit;
  localparam int unsigned MulN = 5;
  localparam int unsigned DivN = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] m_hi, m_lo;

  mdu_unit_if bus ();

  mdu_unit #(
    .MUL_CYCLES(MulN),
    .DIV_CYCLES(DivN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: architectural effect of one accepted operation, from plain 64-bit arithmetic.
  function automatic void model_apply(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd3, 3'd4: begin
        if (b == 32'd0) begin
`ifndef MDU_DIVZERO_HOLD_EN
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
`endif
        end else begin
          if (op == 3'd4) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
          end
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endfunction

  // Issue one op for a cycle; optionally hammer the unit with intr_op while it is busy.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] intr_op);
    logic        is_md;
    int unsigned n;
    is_md = (op >= 3'd1) && (op <= 3'd4);
    n     = (op <= 3'd2) ? MulN : DivN;
    @(negedge clk);
    bus.En = 1'b1; bus.MduOp = op; bus.A = a; bus.B = b;
    #1 chk("start", {31'd0, bus.Start}, {31'd0, is_md});
    @(negedge clk);
    bus.En = 1'b0; bus.MduOp = 3'd0;
    if (is_md) begin
      for (int i = 0; i < int'(n); i++) begin
        if (intr_op != 3'd0) begin
          bus.En = 1'b1; bus.MduOp = intr_op; bus.A = $urandom; bus.B = $urandom;
        end
        #1 chk("busy_high", {31'd0, bus.Busy}, 32'd1);
        if (intr_op != 3'd0) chk("start_blocked", {31'd0, bus.Start}, 32'd0);
        @(negedge clk);
        bus.En = 1'b0; bus.MduOp = 3'd0;
      end
    end
    model_apply(op, a, b);
    #1 chk("busy_low", {31'd0, bus.Busy}, 32'd0);
    chk("hi", bus.HI, m_hi);
    chk("lo", bus.LO, m_lo);
    bus.RdSel = 1'($urandom);
    #1 chk("rd", bus.RD, bus.RdSel ? m_hi : m_lo);
  endtask

  initial begin
    logic [2:0]  op, intr;
    logic [31:0] a, b;
    reset = 1'b0;
    bus.En = 1'b0; bus.MduOp = 3'd0; bus.A = 32'd0; bus.B = 32'd0; bus.RdSel = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    chk("rst_rd", bus.RD, 32'd0);
    reset = 1'b1;

    // Test-plan directed steps
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 3'd0);
    chk("mult_hi_plan", bus.HI, 32'hFFFF_FFFF);
    chk("mult_lo_plan", bus.LO, 32'hFFFF_FFFA);
    bus.RdSel = 1'b1;
    #1 chk("mult_rd_hi", bus.RD, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 3'd0);
    chk("multu_hi_plan", bus.HI, 32'h0000_0001);
    chk("multu_lo_plan", bus.LO, 32'hFFFF_FFFE);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 3'd0);
    chk("div_lo_plan", bus.LO, 32'hFFFF_FFFD);
    chk("div_hi_plan", bus.HI, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 3'd0);
    chk("divu_lo_plan", bus.LO, 32'h7FFF_FFFC);
    chk("divu_hi_plan", bus.HI, 32'd1);
    run_op(3'd4, 32'd5, 32'd0, 3'd0);
`ifdef MDU_DIVZERO_HOLD_EN
    chk("divz_hi_plan", bus.HI, 32'd1);
    chk("divz_lo_plan", bus.LO, 32'h7FFF_FFFC);
`else
    chk("divz_hi_plan", bus.HI, 32'd5);
    chk("divz_lo_plan", bus.LO, 32'hFFFF_FFFF);
`endif
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 3'd0);
    chk("div_ovf_lo", bus.LO, 32'h8000_0000);
    chk("div_ovf_hi", bus.HI, 32'd0);
    run_op(3'd6, 32'h1234_5678, 32'd0, 3'd0);
    chk("mtlo_plan", bus.LO, 32'h1234_5678);
    run_op(3'd1, 32'd7, 32'hFFFF_FFFD, 3'd5);
    chk("mthi_ignored", bus.HI, 32'hFFFF_FFFF);
    run_op(3'd3, 32'd1000, 32'd7, 3'd1);
    run_op(3'd2, 32'hDEAD_BEEF, 32'h1234_5678, 3'd4);
    run_op(3'd7, 32'hAAAA_AAAA, 32'd1, 3'd0);
    run_op(3'd0, 32'h5555_5555, 32'd1, 3'd0);

    // Randomized operations, with occasional zero divisors and overflow operands
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 6));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(16, 31);
      intr = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      run_op(op, a, b, intr);
    end

    // Asynchronous reset on cycle 3 of a divide discards the in-flight result
    @(negedge clk);
    bus.En = 1'b1; bus.MduOp = 3'd3; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    bus.En = 1'b0; bus.MduOp = 3'd0;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    #1 chk("arst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("arst_hi", bus.HI, 32'd0);
    chk("arst_lo", bus.LO, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    run_op(3'd1, 32'd4, 32'd5, 3'd0);
    chk("post_rst_lo", bus.LO, 32'd20);
    chk("post_rst_hi", bus.HI, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage, in parallel with the ALU.
- Executes mult, multu, div, divu, mthi and mtlo. Result is written to internal HI/LO after a fixed latency.
- Supplies HI or LO to the E→M pipeline register for mfhi/mflo.
- Exports Busy so the stall controller holds any MDU-class instruction in D while an operation is in flight.

Parameters:
- MUL_CYCLES, 5, cycles Busy stays high for mult/multu.
- DIV_CYCLES, 10, cycles Busy stays high for div/divu.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- En  in  1  E-stage instruction valid; already 0 for bubbles and cleared slots.
- MduOp  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- A  in  32  forwarded rs value (V1 after E-stage forwarding).
- B  in  32  forwarded rt value (V2 after E-stage forwarding).
- RdSel  in  1  0 selects LO, 1 selects HI onto RD.
- Start  out  1  combinational: En && MduOp in {1..4} && !Busy.
- Busy  out  1  registered; high while a mul/div is in flight.
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.
- RD  out  32  combinational: RdSel ? HI : LO.

Behaviour:
- Reset (reset==0, async):
  - HI=0, LO=0, Busy=0, counter=0, pending results=0, state=IDLE.
  - Takes effect immediately, including mid-operation; an in-flight result is discarded.
- States: IDLE and RUN.
- IDLE:
  - On Start, latch the computed result into pending registers (phi, plo), load the counter with MUL_CYCLES or DIV_CYCLES, set Busy=1 at the next edge, go to RUN.
  - Results are computed combinationally at issue from A/B; the counter models latency only.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter goes 1→0: HI<=phi, LO<=plo, Busy<=0, go to IDLE.
  - Busy is therefore high for exactly N cycles after the Start edge. HI/LO update on the same edge Busy falls.
- Arithmetic:
  - mult: signed 32x32 → 64; HI = upper 32 bits, LO = lower 32 bits.
  - multu: same, unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Boundary: div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (no trap).
  - Divide by zero: see Optional Feature.
- mthi/mtlo:
  - When En && !Busy, HI<=A (or LO<=A) at the next edge; single cycle, Busy stays 0.
  - Issued while Busy: ignored. The stall controller must prevent this case; it is not an error path in this block.
- Simultaneous events:
  - A new mul/div while Busy is ignored (Start=0) and leaves the in-flight operation unaffected.
  - If a new mul/div request coincides with the completion edge, it is ignored; Busy goes 0 that edge.
- Read semantics:
  - RD reflects HI/LO as currently registered.
  - An mfhi/mflo in E while Busy reads stale values; the stall controller holds it in D until Busy==0 && Start==0.
- En==0 or MduOp 0/7: no state change.

Optional Feature:
- Macro: MDU_DIVZERO_HOLD_EN.
- Defined: div/divu with B==0 still asserts Busy for DIV_CYCLES, but HI/LO are left unchanged at completion.
- Undefined: B==0 gives LO=0xFFFFFFFF and HI=A for both div and divu, fully deterministic.

Test Plan:
- mult A=0xFFFFFFFE (-2), B=3, En=1 one cycle → Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; RdSel=1 gives RD=0xFFFFFFFF.
- multu A=0xFFFFFFFF, B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu same operands → LO=0x7FFFFFFC, HI=1.
- divu A=5, B=0 → after 10 cycles: with macro, HI/LO keep prior values; without macro, LO=0xFFFFFFFF, HI=5.
- mtlo A=0x12345678 issued while idle → LO=0x12345678 next edge, Busy stays 0. mthi issued during Busy after a mult → ignored; HI = mult result after completion.
- Assert reset=0 on cycle 3 of a div → Busy, HI and LO go 0 immediately. Release reset, issue mult 4×5 → LO=20 after 5 cycles.
